// File: rtl/spi_package.sv
// Shared definitions for the SPI transmit feeder.
// Purpose: default word width of the SPI master datapath and the feeder FSM state type.
// Ports: none (package).
package spi_package;

  localparam int DATA_WIDTH = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// Circular synchronous FIFO used as the host-side command buffer of spi_tx_feeder.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   push, push_data   write request and word; ignored when full unless a pop happens on the same edge
//   pop               read request; ignored when empty
//   head_data         word at the read pointer (valid when !empty)
//   full, empty       occupancy flags
//   level             number of stored words
module spi_sync_fifo #(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_WIDTH-1:0]      push_data,
  input  logic                       pop,
  output logic [DATA_WIDTH-1:0]      head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty     = (level == '0);
  assign full      = (level == LW'(DEPTH));
  assign head_data = mem[rd_ptr];

  // A pop on the same edge frees a slot, so a write into a full FIFO is still accepted.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/spi_tx_feeder.sv
// Host-side feeder for spi_top: queues command words and hands them to the SPI master
// one at a time over its data_in/new_data/done handshake, with a transfer watchdog and
// sticky error flags so a hung link cannot stall the host.
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   wr_en, wr_data         host write strobe and word
//   full, empty, level     FIFO status
//   spi_data, spi_new_data to spi_top.data_in / spi_top.new_data (1-cycle pulse)
//   spi_done               from spi_top.done
//   busy                   transfer in progress (LAUNCH or WAIT)
//   sent_count             completed transfers, wrapping
//   overflow, timeout_err  sticky error flags
//   clear_err              synchronous clear of both sticky flags
//
// state  | meaning
// IDLE   | no transfer; pops the FIFO head into spi_data when a word is queued
// LAUNCH | spi_new_data pulse, watchdog restarted
// WAIT   | spi_data held until spi_done or watchdog expiry
module spi_tx_feeder #(
  parameter int DATA_WIDTH     = spi_package::DATA_WIDTH,
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [DATA_WIDTH-1:0]      spi_data,
  output logic                       spi_new_data,
  input  logic                       spi_done,
  output logic                       busy,
  output logic [15:0]                sent_count,
  output logic                       overflow,
  output logic                       timeout_err,
  input  logic                       clear_err
);

  import spi_package::*;

  localparam int WDW = $clog2(TIMEOUT_CYCLES);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

  feeder_state_t         state;
  feeder_state_t         state_nxt;
  logic [WDW-1:0]        watchdog;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  pop;
  logic                  done_evt;
  logic                  wd_expire;
  logic                  ovf_evt;

  assign pop       = (state == IDLE) && !empty;
  assign done_evt  = (state == WAIT) && spi_done;
  // Done on the expiry cycle counts as a completed transfer, not a timeout.
  assign wd_expire = (state == WAIT) && !spi_done && (watchdog == WD_LAST);
  assign ovf_evt   = wr_en && full && !pop;

  spi_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .head_data (head_data),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty) state_nxt = LAUNCH;
      LAUNCH:  state_nxt = WAIT;
      WAIT:    if (done_evt || wd_expire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    spi_new_data = 1'b0;
    busy         = 1'b0;
    case (state)
      LAUNCH: begin
        spi_new_data = 1'b1;
        busy         = 1'b1;
      end
      WAIT:    busy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spi_data    <= '0;
      watchdog    <= '0;
      sent_count  <= '0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (pop) spi_data <= head_data;

      if (state == LAUNCH)    watchdog <= '0;
      else if (state == WAIT) watchdog <= watchdog + WDW'(1);

      if (done_evt) sent_count <= sent_count + 16'd1;

      // A new error event outranks a clear on the same edge.
      if (ovf_evt)        overflow <= 1'b1;
      else if (clear_err) overflow <= 1'b0;

      if (wd_expire)      timeout_err <= 1'b1;
      else if (clear_err) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_tx_feeder.sv
module tb_spi_tx_feeder;

  localparam int DW = 12;
  localparam int DEPTH = 8;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // main instance (long watchdog)
  logic          wr_en, clear_err, resp_done, man_done, spi_done;
  logic [DW-1:0] wr_data;
  logic          full, empty, spi_new_data, busy, overflow, timeout_err;
  logic [LW-1:0] level;
  logic [DW-1:0] spi_data;
  logic [15:0]   sent_count;
  assign spi_done = resp_done | man_done;

  spi_tx_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT_CYCLES(1024)) u_dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .level(level),
    .spi_data(spi_data), .spi_new_data(spi_new_data), .spi_done(spi_done),
    .busy(busy), .sent_count(sent_count), .overflow(overflow),
    .timeout_err(timeout_err), .clear_err(clear_err)
  );

  // second instance with a short watchdog
  logic          w_wr_en, w_clear, w_done;
  logic [DW-1:0] w_wr_data;
  logic          w_full, w_empty, w_new_data, w_busy, w_overflow, w_timeout;
  logic [LW-1:0] w_level;
  logic [DW-1:0] w_data;
  logic [15:0]   w_sent;

  spi_tx_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT_CYCLES(16)) u_wd (
    .clk(clk), .reset(reset), .wr_en(w_wr_en), .wr_data(w_wr_data),
    .full(w_full), .empty(w_empty), .level(w_level),
    .spi_data(w_data), .spi_new_data(w_new_data), .spi_done(w_done),
    .busy(w_busy), .sent_count(w_sent), .overflow(w_overflow),
    .timeout_err(w_timeout), .clear_err(w_clear)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: expected words in issue order
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] cur_exp = '0;
  int launches = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (spi_new_data) begin
        launches++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected_launch: got %0h want none", spi_data);
        end else begin
          cur_exp = exp_q.pop_front();
          chk("sb_word", 32'(spi_data), 32'(cur_exp));
        end
      end else if (busy) begin
        chk("wait_hold", 32'(spi_data), 32'(cur_exp));
      end
    end
  end

  // link responder standing in for spi_top
  bit resp_en = 1'b0;
  bit resp_rand = 1'b0;
  int resp_delay = 1;
  int done_pulses = 0;
  initial begin
    int d;
    resp_done = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_en && !reset && spi_new_data) begin
        d = resp_rand ? int'($urandom_range(1, 6)) : resp_delay;
        repeat (d) @(posedge clk);
        #1 resp_done = 1'b1;
        done_pulses++;
        @(posedge clk);
        #1 resp_done = 1'b0;
      end
    end
  end

  task automatic wait_drain(input string name, input int max_cyc);
    int n = 0;
    while ((busy || !empty) && n < max_cyc) begin
      tick();
      n++;
    end
    chk({name, "_drain_bound"}, 32'(busy || !empty), 32'(0));
  endtask

  typedef struct {
    logic [DW-1:0] data;
    logic          clr;
    logic [LW-1:0] exp_level;
    logic          exp_full;
    logic          exp_ovf;
    logic          accept;
  } vec_t;

  vec_t vt[9];

  initial begin
    #300000;
    $display("FAIL global_time_limit: got expired want finished");
    $fatal(1);
  end

  initial begin
    logic [15:0] base;
    int pulses0;
    int n_written;
    logic early;
    logic [DW-1:0] rw;

    for (int i = 0; i < 8; i++) begin
      vt[i].data      = DW'(i + 1);
      vt[i].clr       = 1'b0;
      vt[i].exp_level = LW'(i + 1);
      vt[i].exp_full  = (i == 7);
      vt[i].exp_ovf   = 1'b0;
      vt[i].accept    = 1'b1;
    end
    // 9th write while full and the FSM is stuck in WAIT; clear on the same edge must lose
    vt[8].data      = 12'h009;
    vt[8].clr       = 1'b1;
    vt[8].exp_level = 4'd8;
    vt[8].exp_full  = 1'b1;
    vt[8].exp_ovf   = 1'b1;
    vt[8].accept    = 1'b0;

    wr_en = 0; wr_data = '0; clear_err = 0; man_done = 0;
    w_wr_en = 0; w_wr_data = '0; w_clear = 0; w_done = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_new_data", 32'(spi_new_data), 0);
    chk("rst_data", 32'(spi_data), 0);
    chk("rst_sent", 32'(sent_count), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_tmo", 32'(timeout_err), 0);
    chk("rst_w_flags", 32'({w_full, w_empty, w_level, w_overflow, w_timeout}), 32'b01_0000_00);
    reset = 1'b0;
    tick();

    // single word
    resp_en = 1; resp_delay = 30;
    wr_en = 1; wr_data = 12'hA5C; exp_q.push_back(12'hA5C);
    tick();
    wr_en = 0;
    chk("t1_level", 32'(level), 1);
    chk("t1_no_pulse_yet", 32'(spi_new_data), 0);
    tick();
    chk("t1_pulse", 32'(spi_new_data), 1);
    chk("t1_data", 32'(spi_data), 32'hA5C);
    chk("t1_popped", 32'(empty), 1);
    tick();
    chk("t1_pulse_end", 32'(spi_new_data), 0);
    chk("t1_busy", 32'(busy), 1);
    wait_drain("t1", 100);
    chk("t1_sent", 32'(sent_count), 1);
    chk("t1_launches", 32'(launches), 1);

    // stray done in IDLE
    resp_en = 0;
    man_done = 1; tick(); man_done = 0; tick();
    chk("stray_done_sent", 32'(sent_count), 1);
    chk("stray_done_busy", 32'(busy), 0);

    // burst into full FIFO while one word sits in WAIT
    wr_en = 1; wr_data = 12'h0FF; exp_q.push_back(12'h0FF);
    tick(); wr_en = 0;
    tick(); tick();
    chk("t2_hold_busy", 32'(busy), 1);
    chk("t2_hold_empty", 32'(empty), 1);
    for (int i = 0; i < 9; i++) begin
      wr_en = 1; wr_data = vt[i].data; clear_err = vt[i].clr;
      if (vt[i].accept) exp_q.push_back(vt[i].data);
      tick();
      chk("t2_level", 32'(level), 32'(vt[i].exp_level));
      chk("t2_full", 32'(full), 32'(vt[i].exp_full));
      chk("t2_ovf", 32'(overflow), 32'(vt[i].exp_ovf));
    end
    wr_en = 0; clear_err = 0;
    tick();
    chk("t2_ovf_sticky", 32'(overflow), 1);
    clear_err = 1; tick(); clear_err = 0;
    chk("t2_ovf_cleared", 32'(overflow), 0);

    // push + pop on the same edge while full
    man_done = 1; tick(); man_done = 0;
    chk("t4_done_to_idle", 32'(busy), 0);
    chk("t4_sent", 32'(sent_count), 2);
    wr_en = 1; wr_data = 12'h0AA; exp_q.push_back(12'h0AA);
    tick(); wr_en = 0;
    chk("t4_pp_level", 32'(level), 8);
    chk("t4_pp_full", 32'(full), 1);
    chk("t4_pp_ovf", 32'(overflow), 0);
    chk("t4_pp_launch", 32'(spi_new_data), 1);
    resp_en = 1; resp_delay = 2;
    wait_drain("t2", 400);
    chk("t2_sent_total", 32'(sent_count), 11);
    chk("t2_sb_empty", 32'(exp_q.size()), 0);

    // reset in WAIT with three words queued
    resp_en = 0;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1; wr_data = DW'(12'h301 + i);
      if (i == 0) exp_q.push_back(12'h301);
      tick();
    end
    wr_en = 0;
    tick(); tick();
    chk("t5_pre_level", 32'(level), 3);
    chk("t5_pre_busy", 32'(busy), 1);
    reset = 1'b1;
    #1;
    chk("t5_empty", 32'(empty), 1);
    chk("t5_level", 32'(level), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_new_data", 32'(spi_new_data), 0);
    chk("t5_sent", 32'(sent_count), 0);
    exp_q.delete();
    tick();
    reset = 1'b0;
    tick();
    resp_en = 1; resp_delay = 4;
    wr_en = 1; wr_data = 12'h456; exp_q.push_back(12'h456);
    tick(); wr_en = 0;
    tick();
    chk("t5_relaunch", 32'(spi_new_data), 1);
    wait_drain("t5", 100);
    chk("t5_sent_after", 32'(sent_count), 1);

    // random traffic against the responder
    resp_rand = 1;
    base = sent_count;
    pulses0 = done_pulses;
    n_written = 0;
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      if (!full) begin
        rw = DW'($urandom_range(0, 4095));
        wr_en = 1; wr_data = rw; exp_q.push_back(rw);
        n_written++;
        tick();
        wr_en = 0;
      end
    end
    wait_drain("t6", 600);
    chk("t6_sent_vs_done", 32'(sent_count - base), 32'(done_pulses - pulses0));
    chk("t6_sent_vs_written", 32'(sent_count - base), 32'(n_written));
    chk("t6_sb_empty", 32'(exp_q.size()), 0);
    resp_rand = 0; resp_en = 0;

    // watchdog expiry and done-on-expiry on the short-timeout instance
    w_wr_en = 1; w_wr_data = 12'h111; tick();
    w_wr_data = 12'h222; tick();
    w_wr_en = 0;
    chk("t3_launch", 32'(w_new_data), 1);
    chk("t3_data", 32'(w_data), 32'h111);
    early = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (!w_busy || w_new_data || w_timeout) early = 1'b1;
    end
    chk("t3_no_early_expiry", 32'(early), 0);
    tick();
    chk("t3_tmo", 32'(w_timeout), 1);
    chk("t3_idle", 32'(w_busy), 0);
    chk("t3_sent", 32'(w_sent), 0);
    tick();
    chk("t3_next_launch", 32'(w_new_data), 1);
    chk("t3_next_data", 32'(w_data), 32'h222);
    w_clear = 1; tick(); w_clear = 0;
    chk("t3_cleared", 32'(w_timeout), 0);
    repeat (15) tick();
    chk("t4_still_wait", 32'(w_busy), 1);
    w_done = 1; tick(); w_done = 0;
    chk("t4_exp_done_idle", 32'(w_busy), 0);
    chk("t4_exp_done_sent", 32'(w_sent), 1);
    chk("t4_exp_done_tmo", 32'(w_timeout), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
